// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding and frame timing constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;
  localparam int MID_TICK        = 7;
  localparam int END_TICK        = 15;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/timer_input.sv
// Free-running modulo counter: o_done pulses for one clock every i_final_value+1 enabled clocks.
module timer_input #(
  parameter int N = 11
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_enable,
  input  logic [N-1:0] i_final_value,
  output logic         o_done
);

  logic [N-1:0] r_count;
  logic         w_at_final;

  // A compare of >= lets the counter recover at once if the divisor is lowered mid-count.
  assign w_at_final = (r_count >= i_final_value);
  assign o_done     = i_enable && w_at_final;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_at_final ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 16x oversampled start/data/stop sequencing driven by a
// free-running baud tick, with a 2-flop synchronizer on the serial input.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT       = DBIT_DEFAULT,
  parameter int SB_TICK    = SB_TICK_DEFAULT,
  parameter int TIMER_BITS = 11
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [TIMER_BITS-1:0] baud_final,
  input  logic                  rx,
  output logic [DBIT-1:0]       rx_dout,
  output logic                  rx_done_tick,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int SW = max_int($clog2(SB_TICK), 4);
  localparam int NW = max_int($clog2(DBIT), 1);

  logic            r_rx_meta;
  logic            r_rx_s;
  logic            w_tick;

  rx_state_t       r_state,   w_state_next;
  logic [SW-1:0]   r_s,       w_s_next;
  logic [NW-1:0]   r_n,       w_n_next;
  logic [DBIT-1:0] r_b,       w_b_next;
  logic [DBIT-1:0] r_dout,    w_dout_next;
  logic            r_ferr,    w_ferr_next;
  logic            r_done,    w_done_next;

  // The timer is never restarted, so start-bit alignment is only good to one tick.
  timer_input #(.N(TIMER_BITS)) u_baud_timer (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_enable      (1'b1),
    .i_final_value (baud_final),
    .o_done        (w_tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_ferr  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_n     <= w_n_next;
      r_b     <= w_b_next;
      r_dout  <= w_dout_next;
      r_ferr  <= w_ferr_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_b_next     = r_b;
    w_dout_next  = r_dout;
    w_ferr_next  = r_ferr;
    w_done_next  = 1'b0;

    case (r_state)
      IDLE: begin
        if (!r_rx_s) begin
          w_state_next = START;
          w_s_next     = '0;
        end
      end
      START: begin
        if (w_tick) begin
          // Re-check the line at mid start bit so short glitches are dropped.
          if (r_s == SW'(MID_TICK)) begin
            if (!r_rx_s) begin
              w_state_next = DATA;
              w_s_next     = '0;
              w_n_next     = '0;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_s == SW'(END_TICK)) begin
            w_s_next = '0;
            w_b_next = {r_rx_s, r_b[DBIT-1:1]};
            if (r_n == NW'(DBIT - 1)) begin
              w_state_next = STOP;
            end else begin
              w_n_next = r_n + 1'b1;
            end
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_s == SW'(SB_TICK - 1)) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
            w_dout_next  = r_b;
            w_ferr_next  = ~r_rx_s;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign rx_dout      = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frame table, hand-written corner
// sequences and random frames scored against a bit-level frame model.
module tb_uart_rx_ctrl;

  localparam int TIMER_BITS = 11;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
  } rxResult_t;

  typedef struct {
    logic [7:0]            data;
    logic                  stopHigh;
    int                    gapBits;
    logic [TIMER_BITS-1:0] baud;
    logic [7:0]            expDout;
    logic                  expFerr;
  } vector_t;

  logic                  clk       = 1'b0;
  logic                  rstn      = 1'b0;
  logic [TIMER_BITS-1:0] baudFinal = 11'd4;
  logic                  rx        = 1'b1;
  logic [7:0]            rxDout;
  logic                  rxDoneTick;
  logic                  frameErr;
  logic                  busy;

  logic [TIMER_BITS-1:0] baudZero  = '0;
  logic                  rx32      = 1'b1;
  logic [7:0]            rxDout32;
  logic                  rxDoneTick32;
  logic                  frameErr32;
  logic                  busy32;

  int checks = 0;
  int errors = 0;

  rxResult_t  expQ[$];
  vector_t    vec[7];
  logic [7:0] lastDout = 8'h00;

  int         cycle          = 0;
  int         startCycle     = 0;
  int         pulses         = 0;
  int         holdViolations = 0;
  logic       prevBusy       = 1'b0;
  logic       prevDone       = 1'b0;
  logic       prevRstn       = 1'b0;
  logic [7:0] prevDout       = 8'h00;
  logic       prevFerr       = 1'b0;
  rxResult_t  monExp;
  int         monLat;
  int         monLatMin;

  int         cycle32    = 0;
  int         start32    = 0;
  int         pulses32   = 0;
  int         lat32      = 0;
  logic [7:0] capDout32  = 8'h00;
  logic       capFerr32  = 1'b0;
  logic       prevBusy32 = 1'b0;

  uart_rx_ctrl #(.DBIT(8), .SB_TICK(16), .TIMER_BITS(TIMER_BITS)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .baud_final   (baudFinal),
    .rx           (rx),
    .rx_dout      (rxDout),
    .rx_done_tick (rxDoneTick),
    .frame_err    (frameErr),
    .busy         (busy)
  );

  uart_rx_ctrl #(.DBIT(8), .SB_TICK(32), .TIMER_BITS(TIMER_BITS)) dut32 (
    .clk          (clk),
    .rstn         (rstn),
    .baud_final   (baudZero),
    .rx           (rx32),
    .rx_dout      (rxDout32),
    .rx_done_tick (rxDoneTick32),
    .frame_err    (frameErr32),
    .busy         (busy32)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Receiver samples mid-bit, so it should return exactly the data bits and flag a low stop bit.
  function automatic rxResult_t refModel(input logic [9:0] frame);
    rxResult_t r;
    r.data = frame[8:1];
    r.ferr = ~frame[9];
    return r;
  endfunction

  // Bad stop bits are held low only just past the stop sample point, then the line idles.
  task automatic applyStimulus(input logic [7:0] data, input logic stopHigh, input int gapBits,
                               input logic [7:0] expDout, input logic expFerr);
    logic [9:0] frame;
    rxResult_t  e;
    int         tickClocks;
    frame      = {stopHigh, data, 1'b0};
    e.data     = expDout;
    e.ferr     = expFerr;
    expQ.push_back(e);
    lastDout   = expDout;
    tickClocks = int'(baudFinal) + 1;
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (((i == 9 && !stopHigh) ? 13 : 16) * tickClocks) @(negedge clk);
    end
    rx = 1'b1;
    repeat ((stopHigh ? gapBits : gapBits + 3) * 16 * tickClocks) @(negedge clk);
  endtask

  task automatic waitIdle(input string name);
    int budget;
    budget = 0;
    while ((expQ.size() != 0 || busy) && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    checkOutput({name, " drained"}, 32'(expQ.size()), 32'd0);
    checkOutput({name, " idle busy"}, 32'(busy), 32'd0);
  endtask

  // Main-instance scoreboard: pulse contents, width, latency and output hold behaviour.
  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (busy && !prevBusy) startCycle = cycle;
      if (rstn && prevRstn && !rxDoneTick && (rxDout !== prevDout || frameErr !== prevFerr))
        holdViolations++;
      if (rxDoneTick) begin
        pulses++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected pulse: rx_dout 0x%0h, expected no pulse", rxDout);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("rx_dout", 32'(rxDout), 32'(monExp.data));
          checkOutput("frame_err", 32'(frameErr), 32'(monExp.ferr));
          checkOutput("pulse width", 32'(prevDone), 32'd0);
          checkOutput("output hold", 32'(holdViolations), 32'd0);
          monLat    = cycle - startCycle;
          monLatMin = 151 * (int'(baudFinal) + 1) + 1;
          checks++;
          if (monLat < monLatMin || monLat > monLatMin + int'(baudFinal)) begin
            errors++;
            $display("[TB] FAIL latency: got %0d clocks, expected %0d..%0d", monLat, monLatMin,
                     monLatMin + int'(baudFinal));
          end
        end
      end
      prevBusy = busy;
      prevDone = rxDoneTick;
      prevRstn = rstn;
      prevDout = rxDout;
      prevFerr = frameErr;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cycle32++;
      if (busy32 && !prevBusy32) start32 = cycle32;
      if (rxDoneTick32) begin
        pulses32++;
        lat32     = cycle32 - start32;
        capDout32 = rxDout32;
        capFerr32 = frameErr32;
      end
      prevBusy32 = busy32;
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("[TB] FAIL watchdog: got no finish, expected finish within 90000 clocks");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0]            frame;
    logic [9:0]            frame32;
    logic [7:0]            rd;
    logic                  rs;
    rxResult_t             r;
    int                    pulsesBefore;
    int                    budget;
    logic                  sawBusy;

    vec[0] = '{8'hA5, 1'b1, 2, 11'd4, 8'hA5, 1'b0};
    vec[1] = '{8'h3C, 1'b0, 2, 11'd4, 8'h3C, 1'b1};
    vec[2] = '{8'h00, 1'b1, 0, 11'd4, 8'h00, 1'b0};
    vec[3] = '{8'hFF, 1'b1, 0, 11'd4, 8'hFF, 1'b0};
    vec[4] = '{8'h55, 1'b1, 2, 11'd4, 8'h55, 1'b0};
    vec[5] = '{8'hC3, 1'b1, 1, 11'd1, 8'hC3, 1'b0};
    vec[6] = '{8'h0F, 1'b0, 2, 11'd0, 8'h0F, 1'b1};

    rstn = 1'b0;
    rx   = 1'b1;
    rx32 = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset rx_dout", 32'(rxDout), 32'd0);
    checkOutput("reset rx_done_tick", 32'(rxDoneTick), 32'd0);
    checkOutput("reset frame_err", 32'(frameErr), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset busy32", 32'(busy32), 32'd0);
    #2 rstn = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("idle busy", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      baudFinal = vec[i].baud;
      applyStimulus(vec[i].data, vec[i].stopHigh, vec[i].gapBits, vec[i].expDout, vec[i].expFerr);
      if (!vec[i].stopHigh) checkOutput("idle after bad stop", 32'(busy), 32'd0);
    end
    waitIdle("table");
    checkOutput("table pulse count", 32'(pulses), 32'd7);

    // A 3-tick low glitch must enter START, fall back to IDLE and leave the output alone.
    baudFinal    = 11'd4;
    repeat (16 * 5) @(negedge clk);
    pulsesBefore = pulses;
    sawBusy      = 1'b0;
    rx           = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (busy) sawBusy = 1'b1;
    end
    rx     = 1'b1;
    budget = 0;
    while ((busy || !sawBusy) && budget < 200) begin
      @(negedge clk);
      if (busy) sawBusy = 1'b1;
      budget++;
    end
    checkOutput("glitch entered start", 32'(sawBusy), 32'd1);
    checkOutput("glitch back to idle", 32'(busy), 32'd0);
    checkOutput("glitch no pulse", 32'(pulses), 32'(pulsesBefore));
    checkOutput("glitch rx_dout kept", 32'(rxDout), 32'(lastDout));

    // Reset in the middle of data bit 4, then a clean frame afterwards.
    frame = {1'b1, 8'hF0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = frame[i];
      repeat (16 * 5) @(negedge clk);
    end
    rx = frame[5];
    repeat (8 * 5) @(negedge clk);
    checkOutput("busy before reset", 32'(busy), 32'd1);
    #2 rstn = 1'b0;
    @(negedge clk);
    checkOutput("mid reset rx_dout", 32'(rxDout), 32'd0);
    checkOutput("mid reset frame_err", 32'(frameErr), 32'd0);
    checkOutput("mid reset rx_done_tick", 32'(rxDoneTick), 32'd0);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    repeat (4 * 16 * 5) @(negedge clk);
    checkOutput("no pulse after reset", 32'(pulses), 32'(pulsesBefore));
    applyStimulus(8'h81, 1'b1, 2, 8'h81, 1'b0);
    waitIdle("post reset");

    for (int k = 0; k < 16; k++) begin
      baudFinal = TIMER_BITS'($urandom_range(0, 5));
      rd        = 8'($urandom);
      rs        = ($urandom_range(0, 3) != 0);
      frame     = {rs, rd, 1'b0};
      r         = refModel(frame);
      applyStimulus(rd, rs, int'($urandom_range(0, 2)), r.data, r.ferr);
    end
    waitIdle("random");

    // Two stop bits at one tick per clock on the second instance.
    frame32 = {1'b1, 8'h7E, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx32 = frame32[i];
      repeat ((i == 9) ? 32 : 16) @(negedge clk);
    end
    rx32 = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("sb32 pulse count", 32'(pulses32), 32'd1);
    checkOutput("sb32 rx_dout", 32'(capDout32), 32'h7E);
    checkOutput("sb32 frame_err", 32'(capFerr32), 32'd0);
    checkOutput("sb32 latency", 32'(lat32), 32'd168);
    checkOutput("sb32 idle busy", 32'(busy32), 32'd0);

    checkOutput("final output hold", 32'(holdViolations), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
